// File: rtl/regwb_pkg.sv
// Shared register-bank constants, the buffered writeback entry and the write-port grant encoding.
package regwb_pkg;

    localparam int REG_IDX_W = 4;
    localparam int NUM_REGS  = 16;
    localparam int XLEN      = 32;

    localparam logic [REG_IDX_W-1:0] X0 = '0;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_PIPE,
        GRANT_FIFO
    } grant_t;

    function automatic logic is_x0(input logic [REG_IDX_W-1:0] idx);
        return idx == X0;
    endfunction

endpackage

// File: rtl/regwb_fifo.sv
// Synchronous FIFO holding multi-cycle results until they win the register write port.
module regwb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 36
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage is deliberately not reset; only the pointers define validity.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regwb_arbiter.sv
// Arbitrates the single register-bank write port between pipeline writeback and buffered
// multi-cycle results, tracking pending destinations to stall hazardous decodes.
module regwb_arbiter
    import regwb_pkg::*;
#(
    parameter int FIFO_DEPTH      = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_MAX      = 3
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               pipe_we,
    input  logic [REG_IDX_W-1:0]               pipe_rd,
    input  logic [XLEN-1:0]                    pipe_data,
    output logic                               pipe_hold,
    input  logic                               mc_issue,
    input  logic [REG_IDX_W-1:0]               mc_issue_rd,
    output logic                               mc_issue_ok,
    input  logic                               mc_valid,
    input  logic [REG_IDX_W-1:0]               mc_rd,
    input  logic [XLEN-1:0]                    mc_data,
    output logic                               mc_ready,
    input  logic [REG_IDX_W-1:0]               rs1,
    input  logic [REG_IDX_W-1:0]               rs2,
    output logic                               stall,
    output logic                               wreg,
    output logic [REG_IDX_W-1:0]               write_reg,
    output logic [XLEN-1:0]                    write_data,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam int AGE_W = $clog2(STARVE_MAX + 1);
    localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(STARVE_MAX - 1);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    logic [AGE_W-1:0]    age;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_push;
    logic                fifo_pop;
    logic                issue_fire;
    wb_entry_t           head;
    wb_entry_t           push_entry;
    grant_t              grant;

    assign push_entry  = '{rd: mc_rd, data: mc_data};
    assign mc_ready    = reset && !fifo_full;
    assign fifo_push   = mc_valid && mc_ready;
    assign mc_issue_ok = reset && !busy[mc_issue_rd] && (outstanding < OUT_W'(MAX_OUTSTANDING));
    assign issue_fire  = mc_issue && mc_issue_ok;
    assign fifo_pop    = (grant == GRANT_FIFO);

    regwb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(wb_entry_t))
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head)
    );

    // pipe_hold forces the FIFO head through even if the pipeline misbehaves and writes anyway.
    always_comb begin
        grant      = GRANT_NONE;
        wreg       = 1'b0;
        write_reg  = '0;
        write_data = '0;
        if (reset) begin
            if (pipe_we && !pipe_hold) begin
                grant = GRANT_PIPE;
            end else if (!fifo_empty) begin
                grant = GRANT_FIFO;
            end
        end
        case (grant)
            GRANT_PIPE: begin
                wreg       = !is_x0(pipe_rd);
                write_reg  = pipe_rd;
                write_data = pipe_data;
            end
            GRANT_FIFO: begin
                wreg       = !is_x0(head.rd);
                write_reg  = head.rd;
                write_data = head.data;
            end
            default: begin
            end
        endcase
    end

    assign stall = !reset || pipe_hold
                 || (!is_x0(rs1) && busy[rs1])
                 || (!is_x0(rs2) && busy[rs2])
                 || (pipe_we && !is_x0(pipe_rd) && busy[pipe_rd]);

    always_comb begin
        busy_next = busy;
        if (fifo_pop && !is_x0(head.rd)) begin
            busy_next[head.rd] = 1'b0;
        end
        if (issue_fire && !is_x0(mc_issue_rd)) begin
            busy_next[mc_issue_rd] = 1'b1;
        end
    end

    // Age saturates at the limit; the forced grant that follows always clears it.
    always_ff @(posedge clock) begin
        if (!reset) begin
            busy        <= '0;
            outstanding <= '0;
            age         <= '0;
            pipe_hold   <= 1'b0;
        end else begin
            busy <= busy_next;
            case ({issue_fire, fifo_pop})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: outstanding <= outstanding;
            endcase
            if (fifo_pop) begin
                age <= '0;
            end else if (!fifo_empty && age != AGE_LIMIT) begin
                age <= age + AGE_W'(1);
            end
            pipe_hold <= !fifo_empty && !fifo_pop && (age == AGE_LIMIT);
        end
    end

endmodule

// File: tb/tb_regwb_arbiter.sv
// Directed scoreboard bench for regwb_arbiter: expected bank writes are queued by the stimulus
// and popped by a monitor whenever the arbiter drives a write.
module tb_regwb_arbiter;
    import regwb_pkg::*;

    logic        clock;
    logic        reset;
    logic        pipe_we;
    logic [3:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        pipe_hold;
    logic        mc_issue;
    logic [3:0]  mc_issue_rd;
    logic        mc_issue_ok;
    logic        mc_valid;
    logic [3:0]  mc_rd;
    logic [31:0] mc_data;
    logic        mc_ready;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic        stall;
    logic        wreg;
    logic [3:0]  write_reg;
    logic [31:0] write_data;
    logic [2:0]  outstanding;

    int checks;
    int failures;
    wb_entry_t exp_q[$];

    regwb_arbiter #(
        .FIFO_DEPTH      (2),
        .MAX_OUTSTANDING (4),
        .STARVE_MAX      (3)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .pipe_we     (pipe_we),
        .pipe_rd     (pipe_rd),
        .pipe_data   (pipe_data),
        .pipe_hold   (pipe_hold),
        .mc_issue    (mc_issue),
        .mc_issue_rd (mc_issue_rd),
        .mc_issue_ok (mc_issue_ok),
        .mc_valid    (mc_valid),
        .mc_rd       (mc_rd),
        .mc_data     (mc_data),
        .mc_ready    (mc_ready),
        .rs1         (rs1),
        .rs2         (rs2),
        .stall       (stall),
        .wreg        (wreg),
        .write_reg   (write_reg),
        .write_data  (write_data),
        .outstanding (outstanding)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic expect_write(input logic [3:0] rd, input logic [31:0] data);
        exp_q.push_back('{rd: rd, data: data});
    endtask

    // Advance one cycle, drive every input just after the edge, then let the comb outputs settle.
    task automatic apply_stimulus(input logic p_we, input logic [3:0] p_rd, input logic [31:0] p_data,
                                  input logic i_issue, input logic [3:0] i_rd,
                                  input logic v, input logic [3:0] v_rd, input logic [31:0] v_data,
                                  input logic [3:0] s1, input logic [3:0] s2);
        @(posedge clock);
        #1;
        pipe_we     = p_we;
        pipe_rd     = p_rd;
        pipe_data   = p_data;
        mc_issue    = i_issue;
        mc_issue_rd = i_rd;
        mc_valid    = v;
        mc_rd       = v_rd;
        mc_data     = v_data;
        rs1         = s1;
        rs2         = s2;
        #1;
    endtask

    // Monitor: every bank write must match the oldest queued expectation.
    always @(negedge clock) begin
        if (wreg !== 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_write: got reg %0d data 0x%0h, expected no write at %0t",
                         write_reg, write_data, $time);
            end else begin
                wb_entry_t e;
                e = exp_q.pop_front();
                check_output("write_reg", {28'd0, write_reg}, {28'd0, e.rd});
                check_output("write_data", write_data, e.data);
            end
        end
        if (reset === 1'b1 && pipe_hold === 1'b1 && pipe_we === 1'b1) begin
            $error("[TB] protocol violation: pipe_we asserted during pipe_hold");
        end
        if (reset === 1'b1 && outstanding > 3'd4) begin
            checks++;
            failures++;
            $display("[TB] FAIL outstanding_bound: got %0d, expected at most 4", outstanding);
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        reset       = 1'b0;
        pipe_we     = 1'b0;
        pipe_rd     = '0;
        pipe_data   = '0;
        mc_issue    = 1'b0;
        mc_issue_rd = '0;
        mc_valid    = 1'b1;
        mc_rd       = 4'd9;
        mc_data     = 32'h99;
        rs1         = '0;
        rs2         = '0;

        // Reset held three cycles with a result offered
        repeat (3) begin
            @(posedge clock);
            #2;
            check_output("rst_wreg", {31'd0, wreg}, 32'd0);
            check_output("rst_mc_ready", {31'd0, mc_ready}, 32'd0);
            check_output("rst_stall", {31'd0, stall}, 32'd1);
            check_output("rst_issue_ok", {31'd0, mc_issue_ok}, 32'd0);
        end
        reset    = 1'b1;
        mc_valid = 1'b0;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_output("post_rst_outstanding", {29'd0, outstanding}, 32'd0);
        check_output("post_rst_mc_ready", {31'd0, mc_ready}, 32'd1);
        check_output("post_rst_issue_ok", {31'd0, mc_issue_ok}, 32'd1);
        check_output("post_rst_stall", {31'd0, stall}, 32'd0);
        check_output("post_rst_hold", {31'd0, pipe_hold}, 32'd0);

        // Single multi-cycle op to x5 with idle pipeline
        apply_stimulus(0, 0, 0, 1, 5, 0, 0, 0, 0, 0);
        check_output("t2_issue_ok", {31'd0, mc_issue_ok}, 32'd1);
        apply_stimulus(0, 0, 0, 0, 5, 0, 0, 0, 5, 0);
        check_output("t2_stall_busy", {31'd0, stall}, 32'd1);
        check_output("t2_outstanding1", {29'd0, outstanding}, 32'd1);
        check_output("t2_issue_ok_busy", {31'd0, mc_issue_ok}, 32'd0);
        apply_stimulus(0, 0, 0, 0, 5, 1, 5, 32'hDEADBEEF, 5, 0);
        expect_write(5, 32'hDEADBEEF);
        check_output("t2_no_bypass", {31'd0, wreg}, 32'd0);
        check_output("t2_stall_accept", {31'd0, stall}, 32'd1);
        apply_stimulus(0, 0, 0, 0, 5, 0, 0, 0, 5, 0);
        check_output("t2_wreg", {31'd0, wreg}, 32'd1);
        check_output("t2_stall_retire", {31'd0, stall}, 32'd1);
        apply_stimulus(0, 0, 0, 0, 5, 0, 0, 0, 5, 0);
        check_output("t2_stall_clear", {31'd0, stall}, 32'd0);
        check_output("t2_outstanding0", {29'd0, outstanding}, 32'd0);
        check_output("t2_issue_ok_again", {31'd0, mc_issue_ok}, 32'd1);

        // Starvation: pipeline writes x3 every cycle while x7 result waits
        apply_stimulus(1, 3, 32'h300, 1, 7, 0, 0, 0, 0, 0);
        expect_write(3, 32'h300);
        apply_stimulus(1, 3, 32'h301, 0, 0, 1, 7, 32'h7777, 0, 0);
        expect_write(3, 32'h301);
        for (int i = 2; i <= 4; i++) begin
            apply_stimulus(1, 3, 32'h300 + i, 0, 0, 0, 0, 0, 7, 0);
            expect_write(3, 32'h300 + i);
            check_output("t3_hold_low", {31'd0, pipe_hold}, 32'd0);
            check_output("t3_stall_busy7", {31'd0, stall}, 32'd1);
        end
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_write(7, 32'h7777);
        check_output("t3_hold_high", {31'd0, pipe_hold}, 32'd1);
        check_output("t3_hold_stall", {31'd0, stall}, 32'd1);
        check_output("t3_hold_wreg", {31'd0, wreg}, 32'd1);
        apply_stimulus(1, 3, 32'h306, 0, 0, 0, 0, 0, 7, 0);
        expect_write(3, 32'h306);
        check_output("t3_hold_drop", {31'd0, pipe_hold}, 32'd0);
        check_output("t3_stall_free", {31'd0, stall}, 32'd0);
        check_output("t3_outstanding0", {29'd0, outstanding}, 32'd0);

        // Outstanding limit and full FIFO under continuous pipeline writes
        for (int r = 1; r <= 4; r++) begin
            apply_stimulus(0, 0, 0, 1, r[3:0], 0, 0, 0, 0, 0);
            check_output("t4_issue_ok", {31'd0, mc_issue_ok}, 32'd1);
        end
        apply_stimulus(0, 0, 0, 1, 8, 0, 0, 0, 0, 0);
        check_output("t4_limit_ok", {31'd0, mc_issue_ok}, 32'd0);
        check_output("t4_outstanding4", {29'd0, outstanding}, 32'd4);
        apply_stimulus(1, 10, 32'hA05, 0, 8, 1, 1, 32'h11, 8, 0);
        expect_write(10, 32'hA05);
        check_output("t4_ignored_issue", {29'd0, outstanding}, 32'd4);
        check_output("t4_no_busy8", {31'd0, stall}, 32'd0);
        check_output("t4_ready_c5", {31'd0, mc_ready}, 32'd1);
        apply_stimulus(1, 10, 32'hA06, 0, 8, 1, 2, 32'h22, 0, 0);
        expect_write(10, 32'hA06);
        check_output("t4_ready_c6", {31'd0, mc_ready}, 32'd1);
        apply_stimulus(1, 10, 32'hA07, 0, 8, 1, 3, 32'h33, 0, 0);
        expect_write(10, 32'hA07);
        check_output("t4_full_c7", {31'd0, mc_ready}, 32'd0);
        apply_stimulus(1, 10, 32'hA08, 0, 8, 1, 3, 32'h33, 0, 0);
        expect_write(10, 32'hA08);
        check_output("t4_full_c8", {31'd0, mc_ready}, 32'd0);
        check_output("t4_hold_c8", {31'd0, pipe_hold}, 32'd0);
        apply_stimulus(0, 0, 0, 0, 8, 1, 3, 32'h33, 0, 0);
        expect_write(1, 32'h11);
        check_output("t4_hold_c9", {31'd0, pipe_hold}, 32'd1);
        check_output("t4_full_while_pop", {31'd0, mc_ready}, 32'd0);
        apply_stimulus(1, 10, 32'hA0A, 0, 8, 1, 3, 32'h33, 0, 0);
        expect_write(10, 32'hA0A);
        check_output("t4_ready_after_pop", {31'd0, mc_ready}, 32'd1);
        check_output("t4_outstanding3", {29'd0, outstanding}, 32'd3);
        check_output("t4_issue_ok_reopen", {31'd0, mc_issue_ok}, 32'd1);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_write(2, 32'h22);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_write(3, 32'h33);
        apply_stimulus(0, 0, 0, 0, 0, 1, 4, 32'h44, 0, 0);
        check_output("t4_empty_no_write", {31'd0, wreg}, 32'd0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 4, 0);
        expect_write(4, 32'h44);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 4, 0);
        check_output("t4_outstanding0", {29'd0, outstanding}, 32'd0);
        check_output("t4_stall_clear", {31'd0, stall}, 32'd0);

        // Result destined for x0 is dropped but still retires
        apply_stimulus(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        check_output("t5_issue_ok", {31'd0, mc_issue_ok}, 32'd1);
        apply_stimulus(0, 0, 0, 0, 0, 1, 0, 32'h1, 0, 0);
        check_output("t5_outstanding1", {29'd0, outstanding}, 32'd1);
        check_output("t5_stall", {31'd0, stall}, 32'd0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_output("t5_x0_wreg", {31'd0, wreg}, 32'd0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_output("t5_outstanding0", {29'd0, outstanding}, 32'd0);

        // Reset with two buffered results and x6 pending
        apply_stimulus(0, 0, 0, 1, 6, 0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 1, 13, 0, 0, 0, 0, 0);
        apply_stimulus(1, 2, 32'hB2, 0, 0, 1, 13, 32'hD, 0, 0);
        expect_write(2, 32'hB2);
        apply_stimulus(1, 2, 32'hB3, 0, 0, 1, 6, 32'h6, 6, 0);
        expect_write(2, 32'hB3);
        apply_stimulus(1, 2, 32'hB4, 0, 6, 0, 0, 0, 6, 0);
        check_output("t6_full", {31'd0, mc_ready}, 32'd0);
        check_output("t6_stall_busy6", {31'd0, stall}, 32'd1);
        reset = 1'b0;
        #1;
        check_output("t6_rst_wreg", {31'd0, wreg}, 32'd0);
        check_output("t6_rst_issue_ok", {31'd0, mc_issue_ok}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        pipe_we = 1'b0;
        #1;
        check_output("t6_outstanding0", {29'd0, outstanding}, 32'd0);
        check_output("t6_ready", {31'd0, mc_ready}, 32'd1);
        check_output("t6_busy_cleared", {31'd0, stall}, 32'd0);
        check_output("t6_no_write", {31'd0, wreg}, 32'd0);
        check_output("t6_issue_ok6", {31'd0, mc_issue_ok}, 32'd1);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 6, 0);
        check_output("t6_still_idle", {31'd0, wreg}, 32'd0);
        check_output("t6_hold_low", {31'd0, pipe_hold}, 32'd0);

        @(posedge clock);
        #1;
        check_output("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
